// File: rtl/mac_tx_ctrl_pkg.sv
// Shared MAC TX types and constants: FSM state encoding, IFG/DIC constants and a helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional feature macro used by importers: MAC_TX_DIC_EN (deficit idle count).
//
// Contents:
//   mac_tx_state_t  TX sequencer states
//   MAC_N_CHANNELS  default byte lanes per data word
//   MAC_HDR_CNT     default header (preamble/SFD) words per frame
//   MAC_IFG_BYTES   minimum idle bytes between terminate and next start
//   MAC_DIC_MAX     largest deficit (bytes) the DIC may borrow
//   MAC_DIC_W       width of the deficit register
//   ceil_div()      integer ceiling division for elaboration-time and comb math
package mac_tx_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        IFG   = 3'd4
    } mac_tx_state_t;

    localparam int MAC_N_CHANNELS = 8;
    localparam int MAC_HDR_CNT    = 1;
    localparam int MAC_IFG_BYTES  = 12;
    localparam int MAC_DIC_MAX    = 3;
    localparam int MAC_DIC_W      = 2;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/mac_tx_ifg_calc.sv
// Converts the ctrl lanes of a frame's last word into the number of IFG words to emit.
// Latency: purely combinational; the caller registers the result on the terminating pop.
// Backpressure: none (no handshake, evaluated every cycle).
//
// Optional feature: MAC_TX_DIC_EN adds the deficit idle count ports and rounding.
//
// Ports:
//   i_rctrl        ctrl lanes of the last word; lowest set bit marks the terminate lane
//   o_words        IFG words needed after this frame
//   i_deficit      (DIC only) current deficit in bytes, 0..MAC_DIC_MAX
//   o_deficit_nxt  (DIC only) deficit to carry into the next frame
module mac_tx_ifg_calc
    import mac_tx_ctrl_pkg::*;
#(
    parameter int N_CHANNELS = MAC_N_CHANNELS,
    parameter int IFG_BYTES  = MAC_IFG_BYTES,
    parameter int W_IFG      = 2
) (
    input  logic [N_CHANNELS-1:0] i_rctrl,
    output logic [W_IFG-1:0]      o_words
`ifdef MAC_TX_DIC_EN
    ,
    input  logic [MAC_DIC_W-1:0]  i_deficit,
    output logic [MAC_DIC_W-1:0]  o_deficit_nxt
`endif
);

    always_comb begin : p_calc
        int t;
        int r;
        int need;
        int cl;
`ifdef MAC_TX_DIC_EN
        int fl;
        int m;
        int dec;
        int d;
`endif
        // Terminate lane is the lowest set ctrl bit; a last word with no ctrl
        // bits is treated as fully used (terminate in the top lane).
        t = N_CHANNELS - 1;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (i_rctrl[i]) begin
                t = i;
            end
        end
        // Idle bytes already sitting behind the terminate count toward the gap.
        r    = N_CHANNELS - 1 - t;
        need = (IFG_BYTES > r) ? (IFG_BYTES - r) : 0;
        cl   = ceil_div(need, N_CHANNELS);
        o_words = W_IFG'(cl);
`ifdef MAC_TX_DIC_EN
        fl  = need / N_CHANNELS;
        m   = need % N_CHANNELS;
        d   = int'(i_deficit);
        dec = (N_CHANNELS - m) % N_CHANNELS;
        o_deficit_nxt = i_deficit;
        if ((m != 0) && (d + m <= MAC_DIC_MAX)) begin
            // Round down and remember the bytes we shaved off.
            o_words       = W_IFG'(fl);
            o_deficit_nxt = MAC_DIC_W'(d + m);
        end else begin
            // Round up; the extra idle bytes pay back any outstanding deficit.
            o_deficit_nxt = (d > dec) ? MAC_DIC_W'(d - dec) : '0;
        end
`endif
    end

endmodule

// File: rtl/mac_tx_ctrl.sv
// Sequences mac_tx_framegen per frame: header words, buffer data words, then inter-frame gap.
// Latency: outputs decoded combinationally from state; buffer pop is same-cycle (0 latency).
// Backpressure: i_clk_en low freezes all state and suppresses pops/pulses; i_tx_en low only blocks new starts.
//
// Optional feature macro: MAC_TX_DIC_EN (deficit idle count on IFG rounding).
//
// Ports:
//   i_clk, i_reset          clock; synchronous active-high reset (wins over i_clk_en)
//   i_clk_en                state/counters advance only when high
//   i_tx_en                 permits new frame starts
//   i_buf_frame_rdy         FWFT buffer head is the first word of a frame
//   i_buf_empty             FWFT buffer empty
//   i_buf_rlast             head word is the last word of its frame
//   i_buf_rctrl             ctrl lanes of the head word
//   o_buf_ren               pop the head word
//   o_gen_hdr/o_hdr_id      header select and header word index
//   o_gen_data/idle/ifg/error  framegen word type selects
//   o_busy                  sequencer not idle
//   o_frame_done            pulse: last data word popped
//   o_underflow             pulse: buffer ran empty mid-frame
module mac_tx_ctrl
    import mac_tx_ctrl_pkg::*;
#(
    parameter int N_CHANNELS    = MAC_N_CHANNELS,
    parameter int HDR_WORDS     = MAC_HDR_CNT,
    parameter int IFG_BYTES     = MAC_IFG_BYTES,
    parameter int W_MAC_HDR_CNT = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clk_en,
    input  logic                     i_tx_en,
    input  logic                     i_buf_frame_rdy,
    input  logic                     i_buf_empty,
    input  logic                     i_buf_rlast,
    input  logic [N_CHANNELS-1:0]    i_buf_rctrl,
    output logic                     o_buf_ren,
    output logic                     o_gen_hdr,
    output logic [W_MAC_HDR_CNT-1:0] o_hdr_id,
    output logic                     o_gen_data,
    output logic                     o_gen_idle,
    output logic                     o_gen_ifg,
    output logic                     o_gen_error,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_underflow
);

    // Largest IFG word count either path can load (need never exceeds IFG_BYTES).
    localparam int IFG_MAX_WORDS = ceil_div(IFG_BYTES, N_CHANNELS);
    localparam int W_IFG         = $clog2(IFG_MAX_WORDS + 2);

    mac_tx_state_t            state_q, state_d;
    logic [W_MAC_HDR_CNT-1:0] hdr_cnt_q, hdr_cnt_d;
    logic [W_IFG-1:0]         ifg_cnt_q, ifg_cnt_d;
    logic [W_IFG-1:0]         calc_words;
`ifdef MAC_TX_DIC_EN
    logic [MAC_DIC_W-1:0]     deficit_q, deficit_d;
    logic [MAC_DIC_W-1:0]     calc_deficit;
`endif

    // The calculator watches the head word continuously; its result is only
    // captured on the cycle the last word is popped from DATA.
    mac_tx_ifg_calc #(
        .N_CHANNELS (N_CHANNELS),
        .IFG_BYTES  (IFG_BYTES),
        .W_IFG      (W_IFG)
    ) u_ifg_calc (
        .i_rctrl       (i_buf_rctrl),
        .o_words       (calc_words)
`ifdef MAC_TX_DIC_EN
        ,
        .i_deficit     (deficit_q),
        .o_deficit_nxt (calc_deficit)
`endif
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            hdr_cnt_q <= '0;
            ifg_cnt_q <= '0;
`ifdef MAC_TX_DIC_EN
            deficit_q <= '0;
`endif
        end else if (i_clk_en) begin
            state_q   <= state_d;
            hdr_cnt_q <= hdr_cnt_d;
            ifg_cnt_q <= ifg_cnt_d;
`ifdef MAC_TX_DIC_EN
            deficit_q <= deficit_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_cnt_d    = hdr_cnt_q;
        ifg_cnt_d    = ifg_cnt_q;
`ifdef MAC_TX_DIC_EN
        deficit_d    = deficit_q;
`endif
        o_buf_ren    = 1'b0;
        o_gen_hdr    = 1'b0;
        o_hdr_id     = '0;
        o_gen_data   = 1'b0;
        o_gen_idle   = 1'b0;
        o_gen_ifg    = 1'b0;
        o_gen_error  = 1'b0;
        o_frame_done = 1'b0;
        o_underflow  = 1'b0;
        o_busy       = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                o_gen_idle = 1'b1;
                if (i_tx_en && i_buf_frame_rdy) begin
                    state_d   = HDR;
                    hdr_cnt_d = '0;
                end
            end
            HDR: begin
                o_gen_hdr = 1'b1;
                o_hdr_id  = hdr_cnt_q;
                if (hdr_cnt_q == W_MAC_HDR_CNT'(HDR_WORDS - 1)) begin
                    state_d   = DATA;
                    hdr_cnt_d = '0;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + W_MAC_HDR_CNT'(1);
                end
            end
            DATA: begin
                if (i_buf_empty) begin
                    // Framegen emits an error word so the partial frame is
                    // poisoned on the wire; the rest of it is discarded.
                    o_gen_error = 1'b1;
                    o_underflow = i_clk_en;
                    state_d     = DRAIN;
                end else begin
                    o_gen_data = 1'b1;
                    o_buf_ren  = i_clk_en;
                    if (i_buf_rlast) begin
                        o_frame_done = i_clk_en;
                        ifg_cnt_d    = calc_words;
`ifdef MAC_TX_DIC_EN
                        deficit_d    = calc_deficit;
`endif
                        state_d      = IFG;
                    end
                end
            end
            DRAIN: begin
                // Discard the remainder of the aborted frame; the terminate
                // position is meaningless, so use the full conservative gap.
                o_gen_idle = 1'b1;
                o_buf_ren  = i_clk_en & ~i_buf_empty;
`ifdef MAC_TX_DIC_EN
                deficit_d  = '0;
`endif
                if (!i_buf_empty && i_buf_rlast) begin
                    ifg_cnt_d = W_IFG'(IFG_MAX_WORDS);
                    state_d   = IFG;
                end
            end
            IFG: begin
                // A zero count still costs the one cycle spent in this state.
                o_gen_ifg = 1'b1;
                if (ifg_cnt_q <= W_IFG'(1)) begin
                    ifg_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q - W_IFG'(1);
                end
            end
            default: begin
                o_gen_idle = 1'b1;
                state_d    = IDLE;
            end
        endcase

        // While reset is held the state register may still show a mid-frame
        // state; present idle and never touch the buffer.
        if (i_reset) begin
            o_buf_ren    = 1'b0;
            o_gen_hdr    = 1'b0;
            o_hdr_id     = '0;
            o_gen_data   = 1'b0;
            o_gen_idle   = 1'b1;
            o_gen_ifg    = 1'b0;
            o_gen_error  = 1'b0;
            o_frame_done = 1'b0;
            o_underflow  = 1'b0;
            o_busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_tx_ctrl.sv
// Directed bench for mac_tx_ctrl (N_CHANNELS=8, HDR_WORDS=1, IFG_BYTES=12).
// Latency: n/a. Backpressure: a bench-side FWFT buffer model pops on sampled o_buf_ren.
// Expected per-cycle output codes are queued as each frame is loaded, then popped per enabled cycle.
module tb_mac_tx_ctrl;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_clk_en;
    logic       i_tx_en;
    logic       i_buf_frame_rdy;
    logic       i_buf_empty;
    logic       i_buf_rlast;
    logic [7:0] i_buf_rctrl;
    logic       o_buf_ren;
    logic       o_gen_hdr;
    logic [0:0] o_hdr_id;
    logic       o_gen_data;
    logic       o_gen_idle;
    logic       o_gen_ifg;
    logic       o_gen_error;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_underflow;

    always #5 i_clk = ~i_clk;

    mac_tx_ctrl #(
        .N_CHANNELS (8),
        .HDR_WORDS  (1),
        .IFG_BYTES  (12)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_clk_en        (i_clk_en),
        .i_tx_en         (i_tx_en),
        .i_buf_frame_rdy (i_buf_frame_rdy),
        .i_buf_empty     (i_buf_empty),
        .i_buf_rlast     (i_buf_rlast),
        .i_buf_rctrl     (i_buf_rctrl),
        .o_buf_ren       (o_buf_ren),
        .o_gen_hdr       (o_gen_hdr),
        .o_hdr_id        (o_hdr_id),
        .o_gen_data      (o_gen_data),
        .o_gen_idle      (o_gen_idle),
        .o_gen_ifg       (o_gen_ifg),
        .o_gen_error     (o_gen_error),
        .o_busy          (o_busy),
        .o_frame_done    (o_frame_done),
        .o_underflow     (o_underflow)
    );

    // Code bits: busy, hdr, hdr_id, data, idle, ifg, error, ren, frame_done, underflow
    localparam logic [9:0] C_IDLE = 10'b0_0_0_0_1_0_0_0_0_0;
    localparam logic [9:0] C_HDR  = 10'b1_1_0_0_0_0_0_0_0_0;
    localparam logic [9:0] C_DATA = 10'b1_0_0_1_0_0_0_1_0_0;
    localparam logic [9:0] C_LAST = 10'b1_0_0_1_0_0_0_1_1_0;
    localparam logic [9:0] C_IFG  = 10'b1_0_0_0_0_1_0_0_0_0;
    localparam logic [9:0] C_ERR  = 10'b1_0_0_0_0_0_1_0_0_1;
    localparam logic [9:0] C_DRN  = 10'b1_0_0_0_1_0_0_1_0_0;

    typedef struct packed {
        logic       sof;
        logic       last;
        logic [7:0] rctrl;
    } word_t;

    typedef struct packed {
        logic       fe;
        logic [9:0] code;
    } step_t;

    word_t buf_q[$];
    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [9:0] obs_code();
        return {o_busy, o_gen_hdr, o_hdr_id, o_gen_data, o_gen_idle, o_gen_ifg,
                o_gen_error, o_buf_ren, o_frame_done, o_underflow};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit en, input bit fe);
        i_clk_en        = en;
        i_buf_empty     = fe || (buf_q.size() == 0);
        i_buf_frame_rdy = 1'b0;
        i_buf_rlast     = 1'b0;
        i_buf_rctrl     = '0;
        if (buf_q.size() > 0) begin
            i_buf_frame_rdy = !fe && buf_q[0].sof;
            i_buf_rlast     = buf_q[0].last;
            i_buf_rctrl     = buf_q[0].rctrl;
        end
    endtask

    task automatic load_frame(input int n, input int lane);
        word_t      w;
        logic [7:0] msk;
        for (int i = 0; i < n; i++) begin
            msk     = 8'hFF;
            w.sof   = (i == 0);
            w.last  = (i == n - 1);
            w.rctrl = (i == n - 1) ? (msk << lane) : 8'h00;
            buf_q.push_back(w);
        end
    endtask

    task automatic push(input bit fe, input logic [9:0] code);
        step_t s;
        s.fe   = fe;
        s.code = code;
        exp_q.push_back(s);
    endtask

    task automatic frame(input int n, input int lane, input int ifg_words);
        load_frame(n, lane);
        push(0, C_IDLE);
        push(0, C_HDR);
        for (int i = 0; i < n - 1; i++) push(0, C_DATA);
        push(0, C_LAST);
        for (int i = 0; i < ifg_words; i++) push(0, C_IFG);
        push(0, C_IDLE);
    endtask

    // Runs until every queued step has been observed on an enabled cycle.
    task automatic run(input string tag, input bit toggle);
        int    n;
        bit    en;
        step_t s;
        logic  ren;
        n  = 0;
        en = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            s = exp_q[0];
            drive(en, s.fe);
            #1;
            if (en) begin
                s = exp_q.pop_front();
                chk(tag, 32'(obs_code()), 32'(s.code));
            end else begin
                chk({tag, "_hold"}, 32'({o_buf_ren, o_frame_done, o_underflow}), 32'(0));
            end
            ren = o_buf_ren;
            @(posedge i_clk);
            if (ren === 1'b1 && buf_q.size() > 0) buf_q.pop_front();
            @(negedge i_clk);
            n++;
            if (toggle) en = ~en;
        end
        chk({tag, "_timeout"}, 32'(exp_q.size()), 32'(0));
    endtask

    int t4 [4];

    initial begin
`ifdef MAC_TX_DIC_EN
        t4 = '{1, 1, 1, 2};
`else
        t4 = '{2, 2, 2, 2};
`endif
        i_reset = 1'b1;
        i_tx_en = 1'b1;
        drive(1, 0);
        #1;
        chk("reset_out", 32'(obs_code()), 32'(C_IDLE));
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        drive(1, 0);
        #1;
        chk("reset_release", 32'(obs_code()), 32'(C_IDLE));
        @(negedge i_clk);

        // 1: reset held 3 cycles mid-DATA leaves the buffer alone
        load_frame(4, 0);
        push(0, C_IDLE);
        push(0, C_HDR);
        push(0, C_DATA);
        run("t1_pre", 0);
        for (int i = 0; i < 3; i++) begin
            i_reset = 1'b1;
            drive(1, 0);
            #1;
            chk("t1_in_reset", 32'(obs_code()), 32'(C_IDLE));
            @(posedge i_clk);
            @(negedge i_clk);
        end
        chk("t1_buf_untouched", 32'(buf_q.size()), 32'(3));
        i_reset = 1'b0;
        drive(1, 0);
        #1;
        chk("t1_after_reset", 32'(obs_code()), 32'(C_IDLE));
        @(posedge i_clk);
        @(negedge i_clk);
        buf_q.delete();

        // 2: 4-word frame, terminate lane 0 -> need 5 -> 1 IFG word
        frame(4, 0, 1);
        run("t2", 0);

        // 3: terminate lane 7 -> need 12 -> 2 IFG words
        frame(3, 7, 2);
        run("t3", 0);

        // 4: terminate lane 4 -> need 9, four frames in a row
        for (int k = 0; k < 4; k++) begin
            frame(2, 4, t4[k]);
            run("t4", 0);
        end

        // 5: underflow on the 2nd data word, drain, conservative IFG
        load_frame(4, 0);
        push(0, C_IDLE);
        push(0, C_HDR);
        push(0, C_DATA);
        push(1, C_ERR);
        push(0, C_DRN);
        push(0, C_DRN);
        push(0, C_DRN);
        push(0, C_IFG);
        push(0, C_IFG);
        push(0, C_IDLE);
        run("t5", 0);
        chk("t5_buf_drained", 32'(buf_q.size()), 32'(0));

        // 6: test 2 again with clock enable toggling every cycle
        frame(4, 0, 1);
        run("t6", 1);
        chk("t6_buf_drained", 32'(buf_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
